xbar_grant_ctl: RTL
===================

# xbar_grant_ctl

Grant controller for one crossbar output port; consumes the registered winner/segment result of that port's 22-input partial priority enforcer. It forwards gated requests to the enforcer and decodes the one-hot winner plus segment index into a 22-bit grant and a 5-bit data-mux select. It holds the grant for one whole packet, ending on end-of-packet, on abort, or on watchdog expiry. It sits between the input-port request lines and the output-port data multiplexer.

## Interface
- `WDOG_CYCLES`, default 1023: maximum cycles a grant may be held; 0 disables the watchdog. Must fit the 16-bit counter.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `i_req` in 22: raw requests from the input ports.
- `i_eop` in 22: end-of-packet beat flag per input port.
- `o_enf_req` out 22: requests forwarded to the enforcer.
- `i_winner_found` in 1: enforcer result valid.
- `i_winner` in 8: enforcer one-hot winner within the segment.
- `i_third` in 2: enforcer segment index (0..2).
- `o_grant` out 22: one-hot grant, registered.
- `o_sel` out 5: binary index of the granted port, registered.
- `o_busy` out 1: a grant is held.
- `o_abort` out 1: one-cycle pulse; the granted port dropped its request before end-of-packet.
- `o_timeout` out 1: one-cycle pulse; the watchdog released the grant.
- `o_timeout_id` out 5: index of the port released by timeout; holds its value until the next timeout.
- `o_err` out 1: one-cycle pulse; a malformed enforcer result was received.

## Operation
- **FSM states.** IDLE and GRANT.
- **Request forwarding.** `o_enf_req` = `i_req` when state is IDLE and `i_winner_found` is 0; otherwise it is 0 (combinational). This keeps the enforcer from producing a second winner while a grant is pending or held.
- **Index decode (IDLE with `i_winner_found` = 1).** idx = `i_third`×8 + enc(`i_winner`).
- **Malformed result.** Any of the following is malformed:
  - `i_winner` is not one-hot;
  - `i_third` = 3;
  - `i_third` = 2 with `i_winner[7:6]` ≠ 0.
  
  Action: pulse `o_err`, stay in IDLE.
- **Stale result.** `i_req[idx]` = 0: discard silently, stay in IDLE.
- **Valid result.** Go to GRANT. Register `o_grant` = 1<<idx and `o_sel` = idx. Clear the watchdog counter.
- **Release conditions in GRANT, by priority:**
  1. `i_eop[o_sel]` = 1 → normal release.
  2. `i_req[o_sel]` = 0 → release and pulse `o_abort`.
  3. Watchdog counter = `WDOG_CYCLES`−1 with `WDOG_CYCLES` ≠ 0 → release, pulse `o_timeout`, load `o_timeout_id` = `o_sel`.
- **Release action.** Return to IDLE. Clear `o_grant`, `o_busy` and the counter. `o_sel` keeps its last value.
- **Watchdog counter.** 16 bits, increments every GRANT cycle without a release, saturates.
- **Simultaneous events.** `i_eop` together with a dropped request counts as a normal release, with no abort. `i_eop` and `i_req` of ports other than `o_sel` are ignored.
- **Reset.** All outputs and registers go to 0 and state goes to IDLE, asynchronously, including in the middle of a grant.

## Timing
- **Request to grant.** Requests present at cycle t → enforcer result at t+1 → `o_grant`/`o_sel`/`o_busy` valid at t+2. `o_enf_req` is 0 from t+1.
- **Grant hold.** The grant is high during the `i_eop` beat and deasserts on the following cycle.
- **Re-arbitration.** Release at edge u+1 → requests forwarded at u+1 → earliest next grant at u+3. The enforcer output at u+1 reflects zero inputs, so no stale winner is acted on.
- **Pulses.** `o_abort`, `o_timeout` and `o_err` are registered, one cycle long, and asserted on the cycle after the causing condition.
- **Watchdog.** With `WDOG_CYCLES` = N, the grant is high for exactly N cycles.

## Structure
- **Package `xbar_pkg`.**
  - Constants: `XBAR_NREQ`=22, `XBAR_SEG_W`=8, `XBAR_NSEG`=3.
  - State encoding: IDLE/GRANT.
  - Index width of 5.
- **Sub-module `xbar_onehot_enc`.** 8-bit one-hot → 3-bit binary, plus a `onehot_ok` flag. Used for the decode and for the malformed check.

## Test plan
- **Basic grant.** `i_req` = 1<<5 at cycle 0; enforcer model returns found=1, winner=0x20, third=0 at cycle 1 → `o_grant` = 1<<5, `o_sel` = 5 at cycle 2. `o_enf_req` = 0 from cycle 1. `i_eop[5]` at cycle 6 → `o_grant` = 0 at cycle 7, requests forwarded again at cycle 7.
- **Segment 2 decode.** Winner=0x08, third=2, `i_req[19]` = 1 → `o_sel` = 19, `o_grant` = 1<<19. Repeat for third=1, winner=0x80 → `o_sel` = 15.
- **Stale and malformed results.**
  - Winner for port 3 with `i_req[3]` = 0 → no grant, no `o_err`.
  - Third=2, winner=0x40 → `o_err` pulse, no grant.
  - Winner=0x03 → `o_err` pulse, no grant.
  - Third=3 → `o_err` pulse, no grant.
- **Watchdog.** `WDOG_CYCLES` = 4, granted port 10 never asserts `i_eop` → grant high for 4 cycles, then `o_timeout` pulse with `o_timeout_id` = 10. `WDOG_CYCLES` = 0 → grant held for 100+ cycles.
- **Abort.** Granted port 7 drops `i_req` → `o_abort` pulse and release. Drop `i_req` in the same cycle as `i_eop` → release with no `o_abort`.
- **Reset mid-grant.** Assert `rst` in the middle of a grant, between clock edges → `o_grant`, `o_busy` and `o_sel` go to 0 immediately (asynchronous). After deassert, the next request is granted with the normal 2-cycle latency.

Source files
------------

// File: rtl/xbar_grant_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Package : xbar_pkg
// Brief   : Shared constants and state encoding for the crossbar grant
//           controller of one output port.
// Revision: 1.0 - initial release
// ============================================================================
package xbar_pkg;

  // Request-side geometry: 22 input ports split into 3 segments of 8 lanes.
  // The last segment only populates lanes 0..5.
  localparam int XBAR_NREQ  = 22;
  localparam int XBAR_SEG_W = 8;
  localparam int XBAR_NSEG  = 3;

  // Binary port index width and watchdog counter width.
  localparam int XBAR_IDX_W  = 5;
  localparam int XBAR_WDOG_W = 16;

  // Grant controller state encoding.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } xbar_state_e;

endpackage : xbar_pkg
`default_nettype wire

// File: rtl/xbar_onehot_enc.sv
`default_nettype none
// ============================================================================
// Module  : xbar_onehot_enc
// Brief   : 8-bit one-hot to 3-bit binary encoder with a one-hot validity
//           flag (exactly one bit set).
// Revision: 1.0 - initial release
// ============================================================================
module xbar_onehot_enc
  import xbar_pkg::*;
(
  input  logic [XBAR_SEG_W-1:0] i_onehot,
  output logic [2:0]            o_bin,
  output logic                  o_ok
);

  // OR together the indices of set bits; exact for a one-hot input, and
  // the result is discarded by the consumer whenever o_ok is low.
  always_comb begin
    o_bin = 3'd0;
    for (int i = 0; i < XBAR_SEG_W; i++) begin
      if (i_onehot[i]) begin
        o_bin = o_bin | 3'(i);
      end
    end
    o_ok = (i_onehot != '0) && ((i_onehot & (i_onehot - 8'd1)) == '0);
  end

endmodule : xbar_onehot_enc
`default_nettype wire

// File: rtl/xbar_grant_ctl.sv
`default_nettype none
// ============================================================================
// Module  : xbar_grant_ctl
// Brief   : Grant controller for one crossbar output port. Gates requests
//           towards the partial priority enforcer, decodes its registered
//           winner/segment result into a one-hot grant plus mux select, and
//           holds the grant for a whole packet (end-of-packet, abort or
//           watchdog release).
// Revision: 1.0 - initial release
// ============================================================================
module xbar_grant_ctl
  import xbar_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XBAR_NREQ-1:0]  i_req,
  input  logic [XBAR_NREQ-1:0]  i_eop,
  output logic [XBAR_NREQ-1:0]  o_enf_req,
  input  logic                  i_winner_found,
  input  logic [XBAR_SEG_W-1:0] i_winner,
  input  logic [1:0]            i_third,
  output logic [XBAR_NREQ-1:0]  o_grant,
  output logic [XBAR_IDX_W-1:0] o_sel,
  output logic                  o_busy,
  output logic                  o_abort,
  output logic                  o_timeout,
  output logic [XBAR_IDX_W-1:0] o_timeout_id,
  output logic                  o_err
);

  localparam bit                   WDOG_EN   = (WDOG_CYCLES != 0);
  localparam logic [XBAR_WDOG_W-1:0] WDOG_LAST =
    (WDOG_CYCLES == 0) ? '0 : XBAR_WDOG_W'(WDOG_CYCLES - 1);
  localparam int                   EXT_W     = 1 << XBAR_IDX_W;

  xbar_state_e                 state_q, state_d;
  logic [XBAR_NREQ-1:0]        grant_q, grant_d;
  logic [XBAR_IDX_W-1:0]       sel_q, sel_d;
  logic [XBAR_WDOG_W-1:0]      wdog_q, wdog_d;
  logic                        abort_q, abort_d;
  logic                        timeout_q, timeout_d;
  logic [XBAR_IDX_W-1:0]       timeout_id_q, timeout_id_d;
  logic                        err_q, err_d;

  logic [2:0]                  enc_bin;
  logic                        enc_ok;
  logic [XBAR_IDX_W-1:0]       win_idx;
  logic                        malformed;
  logic                        release_now;
  logic [EXT_W-1:0]            req_ext;
  logic [EXT_W-1:0]            eop_ext;

  xbar_onehot_enc u_enc (
    .i_onehot (i_winner),
    .o_bin    (enc_bin),
    .o_ok     (enc_ok)
  );

  // Zero-extend to the full index range so any 5-bit index is in bounds.
  assign req_ext = {{(EXT_W-XBAR_NREQ){1'b0}}, i_req};
  assign eop_ext = {{(EXT_W-XBAR_NREQ){1'b0}}, i_eop};

  // Segment index times 8 plus lane is just a concatenation.
  assign win_idx = {i_third, enc_bin};

  // Reject non-one-hot winners, segment 3, and lanes 6..7 of the partial
  // last segment (ports 22..23 do not exist).
  assign malformed = !enc_ok
                   || (int'(i_third) >= XBAR_NSEG)
                   || ((int'(i_third) == XBAR_NSEG - 1) && (|i_winner[7:6]));

  // Requests only reach the enforcer while idle with no result pending.
  assign o_enf_req = ((state_q == ST_IDLE) && !i_winner_found) ? i_req : '0;

  // Next-state, grant decode, release priority and pulse generation.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    sel_d        = sel_q;
    wdog_d       = wdog_q;
    abort_d      = 1'b0;
    timeout_d    = 1'b0;
    timeout_id_d = timeout_id_q;
    err_d        = 1'b0;
    release_now  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_winner_found) begin
          if (malformed) begin
            err_d = 1'b1;
          end else if (req_ext[win_idx]) begin
            state_d = ST_GRANT;
            grant_d = {{(XBAR_NREQ-1){1'b0}}, 1'b1} << win_idx;
            sel_d   = win_idx;
            wdog_d  = '0;
          end
        end
      end
      ST_GRANT: begin
        if (eop_ext[sel_q]) begin
          release_now = 1'b1;
        end else if (!req_ext[sel_q]) begin
          release_now = 1'b1;
          abort_d     = 1'b1;
        end else if (WDOG_EN && (wdog_q == WDOG_LAST)) begin
          release_now  = 1'b1;
          timeout_d    = 1'b1;
          timeout_id_d = sel_q;
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + 1'b1;
        end

        if (release_now) begin
          state_d = ST_IDLE;
          grant_d = '0;
          wdog_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        wdog_d  = '0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      sel_q        <= '0;
      wdog_q       <= '0;
      abort_q      <= 1'b0;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      sel_q        <= sel_d;
      wdog_q       <= wdog_d;
      abort_q      <= abort_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
      err_q        <= err_d;
    end
  end

  assign o_grant      = grant_q;
  assign o_sel        = sel_q;
  assign o_busy       = (state_q == ST_GRANT);
  assign o_abort      = abort_q;
  assign o_timeout    = timeout_q;
  assign o_timeout_id = timeout_id_q;
  assign o_err        = err_q;

endmodule : xbar_grant_ctl
`default_nettype wire
